// File: rtl/dllp_replay_ctrl.sv
// rtl/dllp_replay_ctrl.sv - data-link-layer ACK/NAK and replay-timer controller
//
// Hands out transmit sequence numbers, tracks the last acknowledged sequence,
// retires TLPs from the retry buffer on forward progress and requests a replay
// on NAK or replay-timer expiry.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   tlp_start_i/_ready_o/seq_o   new-TLP handshake and its assigned sequence
//   ack_nack_i/_vld_i/seq_num_i  received ACK (1) / NAK (0) DLLP
//   release_vld_o/_cnt_o         retry buffer frees release_cnt_o TLPs (pulse)
//   replay_req_o/replay_done_i   replay request level and completion pulse
//   outstanding_o, ackd_seq_o    unacknowledged count, last acknowledged seq
//   replay_num_o                 replay attempt counter
//   link_retrain_o, dl_error_o   retrain request and bad-ACK/NAK pulses
module dllp_replay_ctrl #(
    parameter int SEQ_WIDTH       = 12,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMER_WIDTH     = 16,
    parameter int REPLAY_TIMEOUT  = 711,
    parameter int REPLAY_NUM_MAX  = 3
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     tlp_start_i,
    output logic                                     tlp_start_ready_o,
    output logic [SEQ_WIDTH-1:0]                     tlp_seq_o,
    input  logic                                     ack_nack_i,
    input  logic                                     ack_nack_vld_i,
    input  logic [SEQ_WIDTH-1:0]                     ack_seq_num_i,
    output logic                                     release_vld_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     release_cnt_o,
    output logic                                     replay_req_o,
    input  logic                                     replay_done_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic [SEQ_WIDTH-1:0]                     ackd_seq_o,
    output logic [1:0]                               replay_num_o,
    output logic                                     link_retrain_o,
    output logic                                     dl_error_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [0:0] ST_SEND   = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;

    localparam logic [SEQ_WIDTH-1:0]   MAX_OS       = SEQ_WIDTH'(MAX_OUTSTANDING);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(REPLAY_TIMEOUT - 1);
    localparam logic [1:0]             NUM_MAX      = 2'(REPLAY_NUM_MAX);

    logic [0:0]             state;
    logic [SEQ_WIDTH-1:0]   next_seq;
    logic [SEQ_WIDTH-1:0]   ackd_seq;
    logic [TIMER_WIDTH-1:0] timer;
    logic [1:0]             replay_num;

    logic [SEQ_WIDTH-1:0]   outstanding;
    logic [SEQ_WIDTH-1:0]   ack_dist;
    logic                   in_send;
    logic                   ack_ok;
    logic                   ack_bad;
    logic                   fwd;
    logic                   timer_run;
    logic                   timeout;
    logic                   replay_entry;
    logic                   start_fire;
    logic [1:0]             replay_num_base;
    logic                   retrain;

    // ackd_seq resets to all ones, so next_seq - ackd_seq - 1 is zero at reset
    assign outstanding  = next_seq - ackd_seq - SEQ_WIDTH'(1);
    assign ack_dist     = ack_seq_num_i - ackd_seq;
    assign in_send      = (state == ST_SEND);

    // A sequence number is in range only if it lies between ackd_seq and the
    // newest transmitted TLP, measured modulo the sequence space.
    assign ack_ok       = ack_nack_vld_i && (ack_dist <= outstanding);
    assign ack_bad      = ack_nack_vld_i && !(ack_dist <= outstanding);
    assign fwd          = ack_ok && (ack_dist != '0);

    assign timer_run    = in_send && (outstanding != '0);
    assign timeout      = timer_run && (timer == TIMEOUT_LAST);
    // Timeout and NAK coinciding still produce exactly one replay entry
    assign replay_entry = in_send && (timeout || (ack_ok && !ack_nack_i));

    assign tlp_start_ready_o = in_send && (outstanding < MAX_OS);
    assign start_fire        = tlp_start_i && tlp_start_ready_o;

    // A NAK carrying forward progress first clears replay_num, then the
    // replay entry counts from that cleared value.
    assign replay_num_base = fwd ? 2'd0 : replay_num;
    assign retrain         = (replay_num_base == NUM_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_SEND;
            next_seq       <= '0;
            ackd_seq       <= '1;
            timer          <= '0;
            replay_num     <= '0;
            release_vld_o  <= 1'b0;
            release_cnt_o  <= '0;
            dl_error_o     <= 1'b0;
            link_retrain_o <= 1'b0;
        end else begin
            if (start_fire) begin
                next_seq <= next_seq + SEQ_WIDTH'(1);
            end
            if (fwd) begin
                ackd_seq <= ack_seq_num_i;
            end

            release_vld_o  <= fwd;
            release_cnt_o  <= fwd ? ack_dist[CW-1:0] : '0;
            dl_error_o     <= ack_bad;
            link_retrain_o <= replay_entry && retrain;

            if (replay_entry) begin
                replay_num <= retrain ? 2'd0 : replay_num_base + 2'd1;
            end else if (fwd) begin
                replay_num <= 2'd0;
            end

            // Outside SEND timer_run is low, so the timer stays frozen at 0
            if (replay_entry || fwd) begin
                timer <= '0;
            end else if (timer_run) begin
                timer <= timer + TIMER_WIDTH'(1);
            end

            if (replay_entry) begin
                state <= ST_REPLAY;
            end else if (!in_send && replay_done_i) begin
                state <= ST_SEND;
            end
        end
    end

    assign tlp_seq_o     = next_seq;
    assign ackd_seq_o    = ackd_seq;
    assign outstanding_o = outstanding[CW-1:0];
    assign replay_num_o  = replay_num;
    assign replay_req_o  = (state == ST_REPLAY);

endmodule

// File: tb/tb_dllp_replay_ctrl.sv
// tb/tb_dllp_replay_ctrl.sv - directed scoreboard bench for dllp_replay_ctrl
module tb_dllp_replay_ctrl;

    logic        clk;
    logic        rst;
    logic        tlp_start;
    logic        tlp_start_ready;
    logic [11:0] tlp_seq;
    logic        ack_nack;
    logic        ack_nack_vld;
    logic [11:0] ack_seq_num;
    logic        release_vld;
    logic [2:0]  release_cnt;
    logic        replay_req;
    logic        replay_done;
    logic [2:0]  outstanding;
    logic [11:0] ackd_seq;
    logic [1:0]  replay_num;
    logic        link_retrain;
    logic        dl_error;

    int vectors = 0;
    int errors  = 0;
    int mdl_next;
    int mdl_ackd;
    int seq_q[$];
    int rel_q[$];
    int n;

    dllp_replay_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .tlp_start_i       (tlp_start),
        .tlp_start_ready_o (tlp_start_ready),
        .tlp_seq_o         (tlp_seq),
        .ack_nack_i        (ack_nack),
        .ack_nack_vld_i    (ack_nack_vld),
        .ack_seq_num_i     (ack_seq_num),
        .release_vld_o     (release_vld),
        .release_cnt_o     (release_cnt),
        .replay_req_o      (replay_req),
        .replay_done_i     (replay_done),
        .outstanding_o     (outstanding),
        .ackd_seq_o        (ackd_seq),
        .replay_num_o      (replay_num),
        .link_retrain_o    (link_retrain),
        .dl_error_o        (dl_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        tlp_start    = 1'b0;
        ack_nack     = 1'b1;
        ack_nack_vld = 1'b0;
        ack_seq_num  = '0;
        replay_done  = 1'b0;
        cyc();
        cyc();
        rst      = 1'b0;
        mdl_next = 0;
        mdl_ackd = 4095;
        seq_q.delete();
        rel_q.delete();
    endtask

    task automatic do_start();
        seq_q.push_back(mdl_next);
        tlp_start = 1'b1;
        chk("start_ready", 32'(tlp_start_ready), 32'd1);
        chk("tlp_seq", 32'(tlp_seq), 32'(seq_q.pop_front()));
        cyc();
        tlp_start = 1'b0;
        mdl_next  = (mdl_next + 1) % 4096;
    endtask

    // Expected outcome derived from the modular distance rule
    task automatic do_ack(input logic is_ack, input int seq);
        int d;
        int os;
        logic valid;
        d     = (seq - mdl_ackd) & 4095;
        os    = (mdl_next - mdl_ackd - 1) & 4095;
        valid = (d <= os);
        if (valid && d > 0) rel_q.push_back(d);
        ack_nack     = is_ack;
        ack_nack_vld = 1'b1;
        ack_seq_num  = 12'(seq);
        cyc();
        ack_nack_vld = 1'b0;
        chk("dl_error", 32'(dl_error), 32'(!valid));
        if (valid && d > 0) begin
            chk("release_vld", 32'(release_vld), 32'd1);
            chk("release_cnt", 32'(release_cnt), 32'(rel_q.pop_front()));
            mdl_ackd = seq;
        end else begin
            chk("release_idle", 32'(release_vld), 32'd0);
        end
        chk("ackd_seq", 32'(ackd_seq), 32'(mdl_ackd));
    endtask

    task automatic wait_replay(output int cnt);
        cnt = 0;
        while (replay_req !== 1'b1 && cnt < 2000) begin
            cyc();
            cnt++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        tlp_start    = 1'b0;
        ack_nack     = 1'b1;
        ack_nack_vld = 1'b0;
        ack_seq_num  = '0;
        replay_done  = 1'b0;
        #3;
        chk("rst_ready", 32'(tlp_start_ready), 32'd1);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_ackd", 32'(ackd_seq), 32'd4095);
        chk("rst_seq", 32'(tlp_seq), 32'd0);
        chk("rst_replay_req", 32'(replay_req), 32'd0);
        chk("rst_pulses", {28'd0, release_vld, dl_error, link_retrain, 1'b0}, 32'd0);
        do_reset();

        // Fill the window, then an ignored fifth start
        for (int i = 0; i < 4; i++) do_start();
        chk("full_outstanding", 32'(outstanding), 32'd4);
        chk("full_ready", 32'(tlp_start_ready), 32'd0);
        tlp_start = 1'b1;
        cyc();
        tlp_start = 1'b0;
        chk("ignored_seq", 32'(tlp_seq), 32'd4);
        chk("ignored_outstanding", 32'(outstanding), 32'd4);

        // Partial ACK, duplicate ACK, then full ACK
        do_ack(1'b1, 1);
        chk("ack1_outstanding", 32'(outstanding), 32'd2);
        cyc();
        chk("release_one_cycle", 32'(release_vld), 32'd0);
        do_ack(1'b1, 1);
        do_ack(1'b1, 3);
        chk("ack3_outstanding", 32'(outstanding), 32'd0);

        // Out-of-range ACK
        do_reset();
        do_start();
        do_start();
        do_ack(1'b1, 9);
        chk("bad_ack_outstanding", 32'(outstanding), 32'd2);
        cyc();
        chk("dl_error_one_cycle", 32'(dl_error), 32'd0);

        // Replay timer expiry and REPLAY_NUM rollover
        do_reset();
        do_start();
        for (int k = 1; k <= 4; k++) begin
            wait_replay(n);
            chk("timeout_cycles", 32'(n), 32'd711);
            chk("timeout_replay_num", 32'(replay_num), 32'(k % 4));
            chk("timeout_retrain", 32'(link_retrain), 32'(k == 4));
            chk("replay_ready", 32'(tlp_start_ready), 32'd0);
            if (k < 4) begin
                replay_done = 1'b1;
                cyc();
                replay_done = 1'b0;
                chk("replay_done", 32'(replay_req), 32'd0);
            end
        end
        cyc();
        chk("retrain_one_cycle", 32'(link_retrain), 32'd0);
        chk("still_replaying", 32'(replay_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_abort", 32'(replay_req), 32'd0);
        chk("async_outstanding", 32'(outstanding), 32'd0);
        do_reset();

        // Walk the sequence space up to the wrap point
        for (int i = 0; i < 4094; i++) begin
            seq_q.push_back(mdl_next);
            tlp_start    = 1'b1;
            ack_nack     = 1'b1;
            ack_nack_vld = (i > 0);
            ack_seq_num  = 12'(i - 1);
            if (i > 0) rel_q.push_back(1);
            chk("walk_seq", 32'(tlp_seq), 32'(seq_q.pop_front()));
            cyc();
            mdl_next = (mdl_next + 1) % 4096;
            if (i > 0) begin
                chk("walk_release", {28'd0, release_vld, release_cnt}, {28'd0, 1'b1, 3'(rel_q.pop_front())});
                mdl_ackd = i - 1;
            end
        end
        tlp_start    = 1'b0;
        ack_nack_vld = 1'b0;
        do_ack(1'b1, 4093);
        for (int i = 0; i < 3; i++) do_start();
        chk("wrap_outstanding3", 32'(outstanding), 32'd3);
        do_ack(1'b1, 0);
        chk("wrap_outstanding0", 32'(outstanding), 32'd0);

        // NAK coinciding with timer expiry
        do_reset();
        do_start();
        do_start();
        for (int i = 0; i < 709; i++) cyc();
        chk("pre_timeout_idle", 32'(replay_req), 32'd0);
        do_ack(1'b0, 4095);
        chk("nak_timeout_replay", 32'(replay_req), 32'd1);
        chk("nak_timeout_num", 32'(replay_num), 32'd1);
        do_ack(1'b0, 0);
        chk("nak_in_replay_req", 32'(replay_req), 32'd1);
        chk("nak_in_replay_num", 32'(replay_num), 32'd0);
        chk("nak_in_replay_os", 32'(outstanding), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
